any1_bus_arbiter: RTL and testbench
===================================

Name: any1_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the ANY-1 128-bit system bus (cyc/stb/ack/we/sel/adr/dat).
- Shares the external bus between the instruction-fetch port (master 0) and the load/store port (master 1).
- Sits between the any1oo core's fetch and memory units and the top-level bus pins.
- Provides round-robin fairness, a bus lock for read-modify-write sequences, and one idle turnaround cycle between owners.

Parameters:
- AWID, 32, address width.
- DWID, 128, data width; select width is DWID/8.
- TO_CYCLES, 255, cycles without ack before a timeout abort (used only with the optional feature).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1  fetch-master cycle, strobe, write.
- m0_sel_i  in  DWID/8  fetch byte selects.
- m0_adr_i  in  AWID  fetch address.
- m0_dat_i  in  DWID  fetch write data.
- m0_ack_o  out  1  fetch ack.
- m0_err_o  out  1  fetch bus error.
- m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i  in  1  data-master controls; lock holds the bus for master 1.
- m1_sel_i  in  DWID/8  data-master byte selects.
- m1_adr_i  in  AWID  data-master address.
- m1_dat_i  in  DWID  data-master write data.
- m1_ack_o, m1_err_o  out  1  data-master ack and bus error.
- m_dat_o  out  DWID  read data broadcast to both masters (the same value goes to each).
- vpa_o  out  1  valid program address; high while master 0 owns the bus and cyc_o is high.
- cyc_o, stb_o, we_o  out  1  bus controls.
- sel_o  out  DWID/8  bus byte selects.
- adr_o  out  AWID  bus address.
- dat_o  out  DWID  bus write data.
- ack_i  in  1  bus ack.
- dat_i  in  DWID  bus read data.

Behaviour:
- State machine states: IDLE, OWN0, OWN1, ABORT. Registered state plus `last` (the most recently granted master).
- Reset (rst_i low, asynchronous):
  - state=IDLE, last=0.
  - All outputs low, zero or inactive immediately, including cyc_o, stb_o, vpa_o, both acks and both errs.
  - Any in-flight transfer is dropped.
- IDLE:
  - Only m0_cyc_i high -> OWN0 next cycle.
  - Only m1_cyc_i high -> OWN1 next cycle.
  - Both high -> grant the master that is not `last`. After reset that is master 1.
  - Grant latency: 1 cycle from a request in IDLE to cyc_o high.
- OWNx:
  - Bus outputs (cyc/stb/we/sel/adr/dat) pass combinationally from master x.
  - ack_i is routed only to mx_ack_o; the other master's ack stays 0.
  - m_dat_o = dat_i at all times.
  - The transfer continues while mx_cyc_i stays high, covering multi-beat bursts.
- Leaving OWNx:
  - mx_cyc_i low -> IDLE. cyc_o goes low that same cycle; last=x.
  - The IDLE cycle is mandatory, giving a minimum one-cycle gap between owners, even for the same master.
- Lock:
  - If m1_lock_i is high when OWN1 is exited, the next grant from IDLE goes to master 1 only.
  - Master 0 requests are ignored until master 1 is granted and later exits with m1_lock_i low.
  - m1_lock_i is ignored in every other state.
- Simultaneous events:
  - A new request arriving in the exit cycle is evaluated in the following IDLE cycle.
  - ack_i arriving while cyc_o is low is discarded.
- Non-owner masters see ack=0 and err=0 and must hold their request.

Optional Feature:
- Macro: ANY1_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8..16-bit counter clears on any ack_i and whenever stb_o is low.
  - It increments while stb_o is high without ack.
  - When the count reaches TO_CYCLES, the owner's mx_err_o pulses for 1 cycle and the state goes to ABORT.
  - ABORT forces cyc_o and stb_o low and waits for the owner's cyc to drop, then enters IDLE with last=owner.
  - An ack_i that coincides with the timeout cycle wins: ack is delivered, no err is raised.
- Without the macro: no counter, no ABORT state; m0_err_o and m1_err_o are tied 0.

Decomposition:
- any1_pkg gains:
  - the arbiter state enum (IDLE/OWN0/OWN1/ABORT);
  - a bus-request struct (cyc, stb, we, sel, adr, dat) shared by fetch and load/store;
  - constant ARB_NMASTERS=2.
- Sub-module any1_rr_pick: a two-input round-robin selector with inputs req[1:0] and last, and output grant index. It is reusable if more masters are added later.

Test Plan:
- Reset mid-transfer: master 1 owns the bus, rst_i low at an arbitrary phase -> cyc_o=0 within the same time step; after release, state IDLE and last=0.
- Contention: both cyc rise in the same cycle after reset -> cyc_o high next cycle with adr_o=m1_adr_i (e.g. 32'h0000_0100). After m1 drops cyc, exactly one idle cycle, then adr_o=m0_adr_i (32'hFFFC_0000) with vpa_o=1.
- Burst: m0 holds cyc for 4 acks at addresses FFFC_0000..FFFC_0030 while m1 is requesting -> m1 is not granted until m0 drops cyc; m1_ack_o stays 0 throughout.
- Lock: m1 read with m1_lock_i=1, then m0 and m1 both request -> m1 granted again; after m1 exits with lock=0, m0 is granted next.
- Write routing: m1 write with sel=16'h00FF, dat=128'hDEAD... -> sel_o, dat_o and we_o match m1 exactly; ack_i returns only on m1_ack_o.
- Timeout (feature on, TO_CYCLES=8): ack_i held low -> m0_err_o pulses on cycle 8 of strobe, cyc_o forced low, IDLE after m0 drops cyc. With the feature off, err stays 0 indefinitely.

Source files
------------

// File: rtl/any1_pkg.sv
// any1_pkg: shared arbiter types and constants for the ANY-1 system bus.
package any1_pkg;
    localparam int ARB_NMASTERS = 2;
    localparam int BUS_AWID = 32;
    localparam int BUS_DWID = 128;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} arb_state_t;

    // Sized for the widest bus; narrower instances zero-extend into it.
    typedef struct packed {
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [BUS_DWID/8-1:0] sel;
        logic [BUS_AWID-1:0]   adr;
        logic [BUS_DWID-1:0]   dat;
    } bus_req_t;
endpackage

// File: rtl/any1_rr_pick.sv
// any1_rr_pick: two-input round-robin selector; on contention grants the
// master that was not granted last.
module any1_rr_pick
    import any1_pkg::*;
(
    input  logic [ARB_NMASTERS-1:0] i_req,
    input  logic                    i_last,
    output logic                    o_grant
);
    assign o_grant = &i_req ? ~i_last : i_req[1];
endmodule

// File: rtl/any1_bus_arbiter.sv
// any1_bus_arbiter: two-master round-robin arbiter for the ANY-1 bus with
// lock and idle turnaround. Define ANY1_ARB_TIMEOUT_EN for the ack timeout.
module any1_bus_arbiter
    import any1_pkg::*;
#(
    parameter int AWID      = 32,
    parameter int DWID      = 128,
    parameter int TO_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DWID/8-1:0] m0_sel_i,
    input  logic [AWID-1:0]   m0_adr_i,
    input  logic [DWID-1:0]   m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [DWID/8-1:0] m1_sel_i,
    input  logic [AWID-1:0]   m1_adr_i,
    input  logic [DWID-1:0]   m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DWID-1:0]   m_dat_o,
    output logic              vpa_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [DWID/8-1:0] sel_o,
    output logic [AWID-1:0]   adr_o,
    output logic [DWID-1:0]   dat_o,
    input  logic              ack_i,
    input  logic [DWID-1:0]   dat_i
);
    arb_state_t r_state, w_next;
    logic       r_last, r_lock;
    logic       w_grant, w_own, w_own1, w_cur_cyc, w_to;
    bus_req_t   w_m0, w_m1, w_bus;

    any1_rr_pick u_pick (
        .i_req  ({m1_cyc_i, m0_cyc_i & ~r_lock}),
        .i_last (r_last),
        .o_grant(w_grant)
    );

    assign w_own1    = r_state == OWN1;
    assign w_own     = r_state == OWN0 || w_own1;
    // In ABORT the stalled owner is already recorded in r_last.
    assign w_cur_cyc = (w_own1 || (r_state == ABORT && r_last)) ? m1_cyc_i : m0_cyc_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_own && w_next != r_state) begin
                r_last <= w_own1;
                if (w_own1)
                    r_lock <= m1_lock_i;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = ((m0_cyc_i && !r_lock) || m1_cyc_i) ? (w_grant ? OWN1 : OWN0) : IDLE;
            OWN0, OWN1: w_next = !w_cur_cyc ? IDLE : w_to ? ABORT : r_state;
            ABORT:      w_next = w_cur_cyc ? ABORT : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_m0  = '{m0_cyc_i, m0_stb_i, m0_we_i, (BUS_DWID/8)'(m0_sel_i), BUS_AWID'(m0_adr_i), BUS_DWID'(m0_dat_i)};
        w_m1  = '{m1_cyc_i, m1_stb_i, m1_we_i, (BUS_DWID/8)'(m1_sel_i), BUS_AWID'(m1_adr_i), BUS_DWID'(m1_dat_i)};
        w_bus = r_state == OWN0 ? w_m0 : w_own1 ? w_m1 : '0;
    end

    assign cyc_o    = w_bus.cyc;
    assign stb_o    = w_bus.stb;
    assign we_o     = w_bus.we;
    assign sel_o    = (DWID/8)'(w_bus.sel);
    assign adr_o    = AWID'(w_bus.adr);
    assign dat_o    = DWID'(w_bus.dat);
    assign vpa_o    = r_state == OWN0 && m0_cyc_i;
    assign m0_ack_o = r_state == OWN0 && m0_cyc_i && ack_i;
    assign m1_ack_o = w_own1 && m1_cyc_i && ack_i;
    assign m_dat_o  = dat_i;

`ifdef ANY1_ARB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TO_CYCLES + 1);
    localparam int CW     = CW_RAW < 8 ? 8 : CW_RAW > 16 ? 16 : CW_RAW;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_cnt <= '0;
        else
            r_cnt <= (ack_i || !stb_o) ? '0 : r_cnt + CW'(1);
    end

    // A coincident ack wins over the timeout.
    assign w_to     = cyc_o && stb_o && !ack_i && r_cnt == CW'(TO_CYCLES - 1);
    assign m0_err_o = w_to && r_state == OWN0;
    assign m1_err_o = w_to && w_own1;
`else
    logic w_unused_to;
    assign w_unused_to = TO_CYCLES != 0;
    assign w_to        = 1'b0;
    assign m0_err_o    = 1'b0;
    assign m1_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_any1_bus_arbiter.sv
// tb_any1_bus_arbiter: directed scenarios plus randomized masters, checked
// every cycle against an ownership-level reference model.
module tb_any1_bus_arbiter;
    localparam int TO = 8;
`ifdef ANY1_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_i = 1'b0, ack_i = 1'b0, lock = 1'b0;
    logic [127:0] dat_i = '0;
    logic cyc[2], stb[2], we[2];
    logic [15:0] sel[2];
    logic [31:0] adr[2];
    logic [127:0] dat[2];
    logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, vpa_o, cyc_o, stb_o, we_o;
    logic [15:0] sel_o;
    logic [31:0] adr_o;
    logic [127:0] dat_o, m_dat_o;

    int n_cmp = 0, n_bad = 0;
    int m_owner, m_last, m_run, e_own, beats[2];
    logic m_lock, m_abort, p_ack[2], p_err[2];
    logic e_cyc, e_stb, e_we, e_vpa, e_to, e_ack[2], e_err[2];
    logic [15:0] e_sel;
    logic [31:0] e_adr;
    logic [127:0] e_dat;

    any1_bus_arbiter #(.AWID(32), .DWID(128), .TO_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_lock_i(lock),
        .m1_sel_i(sel[1]), .m1_adr_i(adr[1]), .m1_dat_i(dat[1]),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m_dat_o(m_dat_o), .vpa_o(vpa_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    // Reference: who owns the bus, who went last, whether master 1 holds a lock.
    always_comb begin
        e_own = (m_owner >= 0 && !m_abort) ? m_owner : -1;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_dat = '0;
        if (e_own >= 0) begin
            e_cyc = cyc[e_own]; e_stb = stb[e_own]; e_we = we[e_own];
            e_sel = sel[e_own]; e_adr = adr[e_own]; e_dat = dat[e_own];
        end
        e_ack[0] = e_own == 0 && e_cyc && ack_i;
        e_ack[1] = e_own == 1 && e_cyc && ack_i;
        e_vpa    = e_own == 0 && e_cyc;
        e_to     = TO_EN && e_own >= 0 && e_cyc && e_stb && !ack_i && (m_run + 1 == TO);
        e_err[0] = e_to && e_own == 0;
        e_err[1] = e_to && e_own == 1;
    end

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_owner <= -1; m_last <= 0; m_lock <= 1'b0; m_abort <= 1'b0; m_run <= 0;
            p_ack <= '{1'b0, 1'b0}; p_err <= '{1'b0, 1'b0};
        end else begin
            p_ack <= e_ack; p_err <= e_err;
            m_run <= (e_stb && !ack_i) ? m_run + 1 : 0;
            if (m_owner < 0) begin
                if (cyc[1] && cyc[0] && !m_lock) m_owner <= 1 - m_last;
                else if (cyc[1]) m_owner <= 1;
                else if (cyc[0] && !m_lock) m_owner <= 0;
            end else if (!cyc[m_owner]) begin
                if (m_owner == 1 && !m_abort) m_lock <= lock;
                m_last <= m_owner; m_owner <= -1; m_abort <= 1'b0;
            end else if (e_to) begin
                m_abort <= 1'b1;
                if (m_owner == 1) m_lock <= lock;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc", cyc_o, e_cyc);   chk("stb", stb_o, e_stb);   chk("we", we_o, e_we);
        chk("sel", sel_o, e_sel);   chk("adr", adr_o, e_adr);   chk("dat", dat_o, e_dat);
        chk("ack0", m0_ack_o, e_ack[0]); chk("ack1", m1_ack_o, e_ack[1]);
        chk("err0", m0_err_o, e_err[0]); chk("err1", m1_err_o, e_err[1]);
        chk("vpa", vpa_o, e_vpa);   chk("mdat", m_dat_o, dat_i);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic agent(input int i);
        if (cyc[i]) begin
            if (p_err[i]) cyc[i] = 1'b0;
            else if (p_ack[i]) begin
                beats[i]--;
                if (beats[i] == 0) cyc[i] = 1'b0;
                else begin
                    adr[i] = adr[i] + 32'h10;
                    dat[i] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end else if ($urandom_range(3) == 0) begin
            cyc[i] = 1'b1; beats[i] = $urandom_range(4, 1); we[i] = $urandom_range(1) == 1;
            sel[i] = 16'($urandom); adr[i] = $urandom & 32'hFFFF_FFF0;
            dat[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        stb[i] = cyc[i] && $urandom_range(7) != 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = 0; adr[i] = 0; dat[i] = 0; beats[i] = 0;
        end
        repeat (2) tick;
        chk("reset_cyc", cyc_o, 1'b0);
        chk("reset_vpa", vpa_o, 1'b0);
        rst_i = 1'b1;
        tick;
        // contention right after reset: master 1 wins
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'hFFFC_0000;
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h0000_0100;
        #1 chk("idle_before_grant", cyc_o, 1'b0);
        tick;
        chk("grant_cyc", cyc_o, 1'b1);
        chk("grant_adr_m1", adr_o, 32'h0000_0100);
        chk("grant_vpa", vpa_o, 1'b0);
        ack_i = 1;
        #1 chk("ack_m1", m1_ack_o, 1'b1);
        chk("ack_m0_quiet", m0_ack_o, 1'b0);
        tick;
        ack_i = 0; cyc[1] = 0; stb[1] = 0;
        #1 chk("exit_cyc_low", cyc_o, 1'b0);
        tick;
        chk("gap_cyc_low", cyc_o, 1'b0);
        tick;
        chk("m0_adr", adr_o, 32'hFFFC_0000);
        chk("m0_vpa", vpa_o, 1'b1);
        // burst of four beats from master 0 while master 1 waits
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            adr[0] = 32'hFFFC_0000 + 32'(16 * k); ack_i = 1;
            #1 chk("burst_adr", adr_o, 32'hFFFC_0000 + 32'(16 * k));
            chk("burst_ack0", m0_ack_o, 1'b1);
            chk("burst_ack1", m1_ack_o, 1'b0);
            tick;
        end
        cyc[0] = 0; stb[0] = 0; ack_i = 0;
        #1 chk("burst_end_cyc", cyc_o, 1'b0);
        tick;
        chk("burst_gap", cyc_o, 1'b0);
        tick;
        chk("m1_after_burst", adr_o, 32'h0000_0200);
        // locked read: master 0 must stay blocked until master 1 exits unlocked
        lock = 1; ack_i = 1;
        #1 chk("lock_ack1", m1_ack_o, 1'b1);
        tick;
        ack_i = 0; cyc[1] = 0; stb[1] = 0;
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'hFFFC_0000;
        #1 chk("lock_exit", cyc_o, 1'b0);
        tick;
        lock = 0;
        chk("lock_idle", cyc_o, 1'b0);
        tick;
        chk("lock_blocks_m0", cyc_o, 1'b0);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 16'h00FF; adr[1] = 32'h0000_0300;
        dat[1] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        tick;
        chk("wr_adr", adr_o, 32'h0000_0300);
        chk("wr_we", we_o, 1'b1);
        chk("wr_sel", sel_o, 16'h00FF);
        chk("wr_dat", dat_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
        ack_i = 1;
        #1 chk("wr_ack1", m1_ack_o, 1'b1);
        chk("wr_ack0", m0_ack_o, 1'b0);
        tick;
        ack_i = 0; cyc[1] = 0; stb[1] = 0; we[1] = 0;
        #1 chk("wr_exit", cyc_o, 1'b0);
        tick;
        tick;
        chk("unlock_m0_adr", adr_o, 32'hFFFC_0000);
        chk("unlock_m0_vpa", vpa_o, 1'b1);
        // ack withheld: timeout on strobe cycle TO when the feature is built in
        for (int k = 1; k <= 12; k++) begin
            chk("to_err0", m0_err_o, TO_EN && k == TO);
            chk("to_err1", m1_err_o, 1'b0);
            chk("to_cyc", cyc_o, !TO_EN || k <= TO);
            tick;
        end
        cyc[0] = 0; stb[0] = 0;
        #1 chk("to_drop", cyc_o, 1'b0);
        tick;
        chk("to_idle", cyc_o, 1'b0);
        // asynchronous reset in the middle of a master 1 transfer
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h0000_0400;
        tick;
        chk("pre_rst_cyc", cyc_o, 1'b1);
        ack_i = 1;
        #2 rst_i = 0;
        #1 chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_ack1", m1_ack_o, 1'b0);
        tick;
        rst_i = 1; ack_i = 0; cyc[0] = 1; stb[0] = 1; adr[0] = 32'hFFFC_0000;
        #1 chk("post_rst_idle", cyc_o, 1'b0);
        tick;
        chk("post_rst_last0", adr_o, 32'h0000_0400);
        cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
        repeat (2) tick;
        // randomized traffic with periodic ack stalls
        for (int n = 0; n < 3000; n++) begin
            agent(0);
            agent(1);
            lock = $urandom_range(3) == 0;
            ack_i = (n % 200 < 12) ? 1'b0 : $urandom_range(1) == 1;
            dat_i = {$urandom, $urandom, $urandom, $urandom};
            tick;
        end
        cyc[0] = 0; cyc[1] = 0; stb[0] = 0; stb[1] = 0; ack_i = 0;
        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
